bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//   Downstream consumer of the decade counters: takes NUM_DIGITS packed BCD digits
//   (one dec_counter per digit) and drives a time-multiplexed 7-segment display.
//   Snapshots all digits once per frame so a counter changing mid-scan never shows a
//   torn value. Provides leading-zero blanking, a dash for invalid codes and a
//   frame-done pulse.
// PARAMETERS
//   NUM_DIGITS  4  number of BCD digits scanned; 2..8. Digit 0 is least significant.
//   SCAN_DIV    4  clk cycles each digit is lit; >=1.
// PORTS
//   clk         in   1               system clock, rising edge
//   reset       in   1               asynchronous, active-high; clears all state
//   enable      in   1               1 = scan display, 0 = display dark (IDLE)
//   blank_lz    in   1               1 = blank leading zeros
//   digits_in   in   4*NUM_DIGITS    packed BCD; digit k = digits_in[4k+3:4k]
//   seg_out     out  7               segments {g,f,e,d,c,b,a}, active-high, registered
//   an_out      out  NUM_DIGITS      one-hot digit select, active-high, registered
//   frame_done  out  1               1-cycle pulse when the last digit's slot ends
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, div_cnt=0, idx=0, shadow=0, seg_out=0,
//     an_out=0, frame_done=0. Everything else is synchronous to clk.
//   State machine:
//   - IDLE: an_out=0, seg_out=0, div_cnt=0, idx=0; shadow<=digits_in every cycle.
//     enable=1 at an edge -> SCAN. On that same edge an_out<=1 (digit 0) and seg_out
//     <=decode of the digits_in value sampled at that edge.
//   - SCAN: div_cnt counts 0..SCAN_DIV-1 and wraps. Slot end (tick) is the edge with
//     div_cnt==SCAN_DIV-1: idx<=idx+1, or 0 when idx==NUM_DIGITS-1 (wrap).
//     On a wrap edge: shadow<=digits_in and frame_done<=1; otherwise frame_done<=0.
//     An enable=0 seen at an edge -> IDLE; on that edge an_out<=0, seg_out<=0,
//     frame_done<=0. No partial-frame pulse. Re-enable always restarts at digit 0.
//   - seg_out/an_out are registered from next-state values, so they always match the
//     current idx. Each digit is lit for exactly SCAN_DIV cycles. Frame =
//     NUM_DIGITS*SCAN_DIV cycles.
//   Decode (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; codes A-F
//     (invalid BCD) = 40 (dash, segment g only).
//   Blanking: with blank_lz=1, digit k>0 gives seg_out=00 when shadow digit k is 0 and
//     all shadow digits above k are 0. Digit 0 is never blanked (value 0 shows 3F).
//     An invalid code is non-zero and stops blanking below it. an_out still lights a
//     blanked slot.
//   blank_lz is sampled at every edge with no snapshot. digits_in changes take effect
//     only at a frame wrap or while in IDLE.
// TESTING  (NUM_DIGITS=4, SCAN_DIV=4)
//   1 reset=1 with random inputs -> seg_out=00, an_out=0000, frame_done=0 before any
//     clk edge. Release with enable=0 -> outputs stay 0.
//   2 digits_in=16'h0907, blank_lz=1, enable 0->1 -> an_out 0001/seg 07 for 4 cycles,
//     then 0010/3F, 0100/6F, 1000/00 (blanked). frame_done is high for 1 cycle with
//     an_out returning to 0001.
//   3 Mid-frame (digit 1 lit) change digits_in 16'h0907->16'h1234 -> rest of frame
//     shows 0907. Next frame shows 4F,5B,06... starting 66 on digit 0.
//   4 digits_in=16'h00A0, blank_lz=1 -> digit0 3F, digit1 40, digits 2,3 00.
//     With blank_lz=0: digits 2,3 show 3F.
//   5 Drop enable while digit 2 lit -> next edge an_out=0000, seg_out=00, no
//     frame_done. Re-enable -> digit 0 lit, with the full 4-cycle slot.
//   6 Assert reset mid-slot between clk edges -> outputs clear immediately.
//     After release, scanning restarts at digit 0 from shadow=digits_in.

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// Display-side bundle of the BCD scanner: digit inputs and controls in,
// multiplexed segment/anode drive and frame strobe out.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic                      blank_lz;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [6:0]                seg_out;
  logic [NUM_DIGITS-1:0]     an_out;
  logic                      frame_done;

  modport master (
    output enable, blank_lz, digits_in,
    input  seg_out, an_out, frame_done
  );

  modport slave (
    input  enable, blank_lz, digits_in,
    output seg_out, an_out, frame_done
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment driver for NUM_DIGITS packed BCD digits, with a
// per-frame digit snapshot, leading-zero blanking and a dash for invalid codes.
module bcd_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_display_scanner_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state, state_n;
  logic [DIV_W-1:0]        div_cnt, div_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_n;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    fd_n;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // A digit is blanked only if it and every more significant digit are zero;
  // an invalid code counts as non-zero, so it stops blanking below it.
  function automatic logic [6:0] digit_pattern(
    input logic [IDX_W-1:0]        k,
    input logic [4*NUM_DIGITS-1:0] snap,
    input logic                    blank
  );
    logic       zero_above;
    logic [3:0] d;
    zero_above = 1'b1;
    d          = 4'd0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(k)) zero_above &= (snap[4*j +: 4] == 4'd0);
      if (j == int'(k)) d = snap[4*j +: 4];
    end
    if (blank && (k != '0) && zero_above) return 7'h00;
    return seg_decode(d);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      idx            <= '0;
      shadow         <= '0;
      bus.seg_out    <= '0;
      bus.an_out     <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_n;
      div_cnt        <= div_n;
      idx            <= idx_n;
      shadow         <= shadow_n;
      bus.seg_out    <= seg_n;
      bus.an_out     <= an_n;
      bus.frame_done <= fd_n;
    end
  end

  always_comb begin
    state_n  = state;
    div_n    = div_cnt;
    idx_n    = idx;
    shadow_n = shadow;
    fd_n     = 1'b0;
    seg_n    = 7'h00;
    an_n     = '0;

    case (state)
      IDLE: begin
        div_n    = '0;
        idx_n    = '0;
        shadow_n = bus.digits_in;
        if (bus.enable) state_n = SCAN;
      end
      SCAN: begin
        if (!bus.enable) begin
          state_n = IDLE;
          div_n   = '0;
          idx_n   = '0;
        end else if (div_cnt == LAST_DIV) begin
          div_n = '0;
          if (idx == LAST_IDX) begin
            idx_n    = '0;
            shadow_n = bus.digits_in;
            fd_n     = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs follow the next-state digit so they land in step with idx.
    if (state_n == SCAN) begin
      an_n  = NUM_DIGITS'(1) << idx_n;
      seg_n = digit_pattern(idx_n, shadow_n, bus.blank_lz);
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (4 digits, 4-cycle slots).
module tb_bcd_display_scanner;

  localparam int NUM_DIGITS = 4;
  localparam int SCAN_DIV   = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  bcd_display_scanner_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

  bcd_display_scanner #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"},  32'(bus.an_out),     32'h0);
    chk({tag, "_seg"}, 32'(bus.seg_out),    32'h0);
    chk({tag, "_fd"},  32'(bus.frame_done), 32'h0);
  endtask

  // Checks one full digit slot; frame_done is expected only on its first cycle.
  task automatic check_slot(input string tag, input logic [3:0] an_exp,
                            input logic [6:0] seg_exp, input logic fd_exp);
    for (int c = 0; c < SCAN_DIV; c++) begin
      chk({tag, "_an"},  32'(bus.an_out),     32'(an_exp));
      chk({tag, "_seg"}, 32'(bus.seg_out),    32'(seg_exp));
      chk({tag, "_fd"},  32'(bus.frame_done), (c == 0) ? 32'(fd_exp) : 32'h0);
      tick();
    end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.blank_lz  = 1'b0;
    bus.digits_in = '0;

    // Reset with random inputs, checked before the first clock edge
    #1;
    reset         = 1'b1;
    bus.enable    = 1'($urandom_range(0, 1));
    bus.blank_lz  = 1'($urandom_range(0, 1));
    bus.digits_in = 16'($urandom);
    #1;
    chk_dark("rst_pre_edge");
    tick();
    chk_dark("rst_held");
    bus.enable = 1'b0;
    reset      = 1'b0;
    tick();
    chk_dark("idle_after_rst");
    tick();
    chk_dark("idle_after_rst2");

    // First frame of 0907 with blanking
    bus.digits_in = 16'h0907;
    bus.blank_lz  = 1'b1;
    bus.enable    = 1'b1;
    tick();
    check_slot("f1_d0", 4'b0001, 7'h07, 1'b0);
    check_slot("f1_d1", 4'b0010, 7'h3F, 1'b0);
    check_slot("f1_d2", 4'b0100, 7'h6F, 1'b0);
    check_slot("f1_d3", 4'b1000, 7'h00, 1'b0);

    // Mid-frame input change is held off until the next wrap
    check_slot("f2_d0", 4'b0001, 7'h07, 1'b1);
    bus.digits_in = 16'h1234;
    check_slot("f2_d1", 4'b0010, 7'h3F, 1'b0);
    check_slot("f2_d2", 4'b0100, 7'h6F, 1'b0);
    check_slot("f2_d3", 4'b1000, 7'h00, 1'b0);
    check_slot("f3_d0", 4'b0001, 7'h66, 1'b1);
    check_slot("f3_d1", 4'b0010, 7'h4F, 1'b0);
    check_slot("f3_d2", 4'b0100, 7'h5B, 1'b0);
    check_slot("f3_d3", 4'b1000, 7'h06, 1'b0);

    // Invalid code shows a dash; zeros above it blank only with blank_lz
    bus.enable = 1'b0;
    tick();
    chk_dark("idle_reload");
    bus.digits_in = 16'h00A0;
    bus.enable    = 1'b1;
    tick();
    check_slot("f4_d0", 4'b0001, 7'h3F, 1'b0);
    check_slot("f4_d1", 4'b0010, 7'h40, 1'b0);
    check_slot("f4_d2", 4'b0100, 7'h00, 1'b0);
    check_slot("f4_d3", 4'b1000, 7'h00, 1'b0);
    bus.blank_lz = 1'b0;
    check_slot("f5_d0", 4'b0001, 7'h3F, 1'b1);
    check_slot("f5_d1", 4'b0010, 7'h40, 1'b0);
    check_slot("f5_d2", 4'b0100, 7'h3F, 1'b0);
    check_slot("f5_d3", 4'b1000, 7'h3F, 1'b0);

    // Drop enable while digit 2 is lit: dark, and no frame_done afterwards
    check_slot("f6_d0", 4'b0001, 7'h3F, 1'b1);
    check_slot("f6_d1", 4'b0010, 7'h40, 1'b0);
    chk("f6_d2_an", 32'(bus.an_out), 32'h4);
    tick();
    bus.enable = 1'b0;
    tick();
    chk_dark("disable_edge");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_dark("disabled");
    end
    bus.enable = 1'b1;
    tick();
    check_slot("re_d0", 4'b0001, 7'h3F, 1'b0);
    check_slot("re_d1", 4'b0010, 7'h40, 1'b0);

    // Asynchronous reset between edges, then restart from fresh digits
    chk("pre_rst_an", 32'(bus.an_out), 32'h4);
    #1;
    reset         = 1'b1;
    bus.digits_in = 16'h0058;
    bus.blank_lz  = 1'b1;
    #1;
    chk_dark("async_rst");
    @(negedge clk);
    chk_dark("async_rst_held");
    reset = 1'b0;
    tick();
    check_slot("rs_d0", 4'b0001, 7'h7F, 1'b0);
    check_slot("rs_d1", 4'b0010, 7'h6D, 1'b0);
    check_slot("rs_d2", 4'b0100, 7'h00, 1'b0);
    check_slot("rs_d3", 4'b1000, 7'h00, 1'b0);
    chk("rs_wrap_fd", 32'(bus.frame_done), 32'h1);
    chk("rs_wrap_an", 32'(bus.an_out), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
